// File: rtl/ex_stage_fwd.sv
// Execute stage: ID/EX pipeline register, MEM/WB operand forwarding, ALU, branch target.
// Define EX_TRACE_EN to build registered trace tags; otherwise EX_ins_* are tied to 0.
module ex_stage_fwd (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] id_imm,
    input  logic [31:0] id_inA,
    input  logic [31:0] id_inB,
    input  logic        id_wreg,
    input  logic        id_m2reg,
    input  logic        id_wmem,
    input  logic [3:0]  id_aluc,
    input  logic        id_aluimm,
    input  logic        id_shift,
    input  logic        id_branch,
    input  logic [31:0] id_pc4,
    input  logic        id_regrt,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [1:0]  id_fwda,
    input  logic [1:0]  id_fwdb,
    input  logic [31:0] mem_aluR,
    input  logic [31:0] wb_dest,
    input  logic [3:0]  ID_ins_type,
    input  logic [3:0]  ID_ins_number,
    output logic        ex_wreg,
    output logic        ex_m2reg,
    output logic        ex_wmem,
    output logic        ex_branch,
    output logic [31:0] ex_aluR,
    output logic [31:0] ex_inB,
    output logic [4:0]  ex_destR,
    output logic [31:0] ex_pc,
    output logic        ex_zero,
    output logic [3:0]  EX_ins_type,
    output logic [3:0]  EX_ins_number
);

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_NOR = 4'd5,
        ALU_SLT = 4'd6,
        ALU_SLL = 4'd7,
        ALU_SRL = 4'd8,
        ALU_SRA = 4'd9,
        ALU_LUI = 4'd10
    } alu_op_e;

    logic [31:0] r_imm, r_inA, r_inB, r_pc4;
    logic        r_wreg, r_m2reg, r_wmem, r_aluimm, r_shift, r_branch, r_regrt;
    logic [3:0]  r_aluc;
    logic [4:0]  r_rt, r_rd;
    logic [1:0]  r_fwda, r_fwdb;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its sources, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_imm    <= '0;
            r_inA    <= '0;
            r_inB    <= '0;
            r_pc4    <= '0;
            r_wreg   <= 1'b0;
            r_m2reg  <= 1'b0;
            r_wmem   <= 1'b0;
            r_aluimm <= 1'b0;
            r_shift  <= 1'b0;
            r_branch <= 1'b0;
            r_regrt  <= 1'b0;
            r_aluc   <= '0;
            r_rt     <= '0;
            r_rd     <= '0;
            r_fwda   <= '0;
            r_fwdb   <= '0;
        end else begin
            r_imm    <= id_imm;
            r_inA    <= id_inA;
            r_inB    <= id_inB;
            r_pc4    <= id_pc4;
            r_wreg   <= id_wreg;
            r_m2reg  <= id_m2reg;
            r_wmem   <= id_wmem;
            r_aluimm <= id_aluimm;
            r_shift  <= id_shift;
            r_branch <= id_branch;
            r_regrt  <= id_regrt;
            r_aluc   <= id_aluc;
            r_rt     <= id_rt;
            r_rd     <= id_rd;
            r_fwda   <= id_fwda;
            r_fwdb   <= id_fwdb;
        end
    end

    logic [31:0] w_fwd_a, w_fwd_b, w_op_a, w_op_b, w_alu;

    // Forwarding uses the live MEM/WB values so late producers are seen this cycle.
    always_comb begin
        w_fwd_a = r_inA;
        w_fwd_b = r_inB;
        case (r_fwda)
            2'b01:   w_fwd_a = mem_aluR;
            2'b10:   w_fwd_a = wb_dest;
            default: w_fwd_a = r_inA;
        endcase
        case (r_fwdb)
            2'b01:   w_fwd_b = mem_aluR;
            2'b10:   w_fwd_b = wb_dest;
            default: w_fwd_b = r_inB;
        endcase
    end

    assign w_op_a = r_shift  ? {27'b0, r_imm[10:6]} : w_fwd_a;
    assign w_op_b = r_aluimm ? r_imm : w_fwd_b;

    // NOTE: a default assignment ahead of the case keeps this block latch-free
    // for the undecoded opcodes 11-15.
    always_comb begin
        w_alu = '0;
        case (alu_op_e'(r_aluc))
            ALU_ADD: w_alu = w_op_a + w_op_b;
            ALU_SUB: w_alu = w_op_a - w_op_b;
            ALU_AND: w_alu = w_op_a & w_op_b;
            ALU_OR:  w_alu = w_op_a | w_op_b;
            ALU_XOR: w_alu = w_op_a ^ w_op_b;
            ALU_NOR: w_alu = ~(w_op_a | w_op_b);
            ALU_SLT: w_alu = {31'b0, $signed(w_op_a) < $signed(w_op_b)};
            ALU_SLL: w_alu = w_op_b << w_op_a[4:0];
            ALU_SRL: w_alu = w_op_b >> w_op_a[4:0];
            ALU_SRA: w_alu = $unsigned($signed(w_op_b) >>> w_op_a[4:0]);
            ALU_LUI: w_alu = {w_op_b[15:0], 16'b0};
            default: w_alu = '0;
        endcase
    end

    assign ex_aluR   = w_alu;
    assign ex_zero   = (w_alu == 32'd0);
    assign ex_inB    = w_fwd_b;
    assign ex_destR  = r_regrt ? r_rt : r_rd;
    assign ex_pc     = r_pc4 + {r_imm[29:0], 2'b00};
    assign ex_wreg   = r_wreg;
    assign ex_m2reg  = r_m2reg;
    assign ex_wmem   = r_wmem;
    assign ex_branch = r_branch;

`ifdef EX_TRACE_EN
    logic [3:0] r_ins_type, r_ins_number;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ins_type   <= '0;
            r_ins_number <= '0;
        end else begin
            r_ins_type   <= ID_ins_type;
            r_ins_number <= ID_ins_number;
        end
    end

    assign EX_ins_type   = r_ins_type;
    assign EX_ins_number = r_ins_number;
`else
    logic w_unused_trace;
    assign w_unused_trace = &{1'b0, ID_ins_type, ID_ins_number};
    assign EX_ins_type    = 4'd0;
    assign EX_ins_number  = 4'd0;
`endif

endmodule

// File: tb/tb_ex_stage_fwd.sv
// Scoreboard bench for ex_stage_fwd: expectations are queued when an instruction
// is driven and compared one cycle later; trace expectations follow EX_TRACE_EN.
module tb_ex_stage_fwd;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] id_imm, id_inA, id_inB, id_pc4, mem_aluR, wb_dest;
    logic        id_wreg, id_m2reg, id_wmem, id_aluimm, id_shift, id_branch, id_regrt;
    logic [3:0]  id_aluc, ID_ins_type, ID_ins_number;
    logic [4:0]  id_rt, id_rd;
    logic [1:0]  id_fwda, id_fwdb;
    logic        ex_wreg, ex_m2reg, ex_wmem, ex_branch, ex_zero;
    logic [31:0] ex_aluR, ex_inB, ex_pc;
    logic [4:0]  ex_destR;
    logic [3:0]  EX_ins_type, EX_ins_number;

    always #5 clk = ~clk;

    ex_stage_fwd dut (
        .clk(clk), .rst(rst),
        .id_imm(id_imm), .id_inA(id_inA), .id_inB(id_inB),
        .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_wmem(id_wmem),
        .id_aluc(id_aluc), .id_aluimm(id_aluimm), .id_shift(id_shift),
        .id_branch(id_branch), .id_pc4(id_pc4), .id_regrt(id_regrt),
        .id_rt(id_rt), .id_rd(id_rd), .id_fwda(id_fwda), .id_fwdb(id_fwdb),
        .mem_aluR(mem_aluR), .wb_dest(wb_dest),
        .ID_ins_type(ID_ins_type), .ID_ins_number(ID_ins_number),
        .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem), .ex_branch(ex_branch),
        .ex_aluR(ex_aluR), .ex_inB(ex_inB), .ex_destR(ex_destR), .ex_pc(ex_pc),
        .ex_zero(ex_zero), .EX_ins_type(EX_ins_type), .EX_ins_number(EX_ins_number)
    );

    typedef struct packed {
        logic [31:0] aluR;
        logic [31:0] inB;
        logic [31:0] pc;
        logic [4:0]  destR;
        logic        zero;
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic        branch;
        logic [3:0]  ins_type;
        logic [3:0]  ins_number;
    } obs_t;

    obs_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic obs_t sample();
        obs_t o;
        o = '{aluR: ex_aluR, inB: ex_inB, pc: ex_pc, destR: ex_destR, zero: ex_zero,
              wreg: ex_wreg, m2reg: ex_m2reg, wmem: ex_wmem, branch: ex_branch,
              ins_type: EX_ins_type, ins_number: EX_ins_number};
        return o;
    endfunction

    function automatic obs_t reset_obs();
        obs_t o;
        o = '0;
        o.zero = 1'b1;
        return o;
    endfunction

    // Independent reference ALU used for the randomised cases.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sb;
        sb = b;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a + (~b + 32'd1);
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ~(a | b);
            4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:  return b << a[4:0];
            4'd8:  return b >> a[4:0];
            4'd9:  return sb >>> a[4:0];
            4'd10: return {b[15:0], 16'h0000};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [3:0] trace_exp(input logic [3:0] v);
`ifdef EX_TRACE_EN
        return v;
`else
        return 4'd0 & v;
`endif
    endfunction

    task automatic clear_inputs();
        id_imm = '0; id_inA = '0; id_inB = '0; id_pc4 = '0;
        id_wreg = 0; id_m2reg = 0; id_wmem = 0; id_aluimm = 0; id_shift = 0;
        id_branch = 0; id_regrt = 0; id_aluc = '0; id_rt = '0; id_rd = '0;
        id_fwda = '0; id_fwdb = '0; mem_aluR = '0; wb_dest = '0;
        ID_ins_type = '0; ID_ins_number = '0;
    endtask

    task automatic test_reset();
        obs_t got, e;
        // Nonzero data alongside reset: reset must win.
        id_inA = 32'h1234; id_inB = 32'h5678; id_wreg = 1; id_wmem = 1; id_branch = 1;
        id_rd = 5'd7; id_pc4 = 32'h40; ID_ins_type = 4'd9; ID_ins_number = 4'd2;
        rst = 1'b1;
        q.push_back(reset_obs());
        @(posedge clk); #1;
        got = sample(); e = q.pop_front(); checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL reset got=%h exp=%h", got, e);
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    task automatic test_add();
        obs_t got, e;
        id_inA = 32'd5; id_inB = 32'd7; id_aluc = 4'd0; id_rd = 5'd3; id_wreg = 1;
        e = '{aluR: 32'd12, inB: 32'd7, pc: 32'd0, destR: 5'd3, zero: 1'b0, wreg: 1'b1,
              m2reg: 1'b0, wmem: 1'b0, branch: 1'b0, ins_type: 4'd0, ins_number: 4'd0};
        q.push_back(e);
        @(posedge clk); #1;
        got = sample(); e = q.pop_front(); checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL add got=%h exp=%h", got, e);
        end
        clear_inputs();
    endtask

    task automatic test_forwarding();
        obs_t got, e;
        id_inA = 32'h111; id_inB = 32'h222; id_fwda = 2'b01; id_fwdb = 2'b10;
        id_aluc = 4'd1; id_rd = 5'd4; id_m2reg = 1;
        mem_aluR = 32'h10; wb_dest = 32'h20;
        e = '{aluR: 32'hFFFF_FFF0, inB: 32'h20, pc: 32'd0, destR: 5'd4, zero: 1'b0,
              wreg: 1'b0, m2reg: 1'b1, wmem: 1'b0, branch: 1'b0, ins_type: 4'd0,
              ins_number: 4'd0};
        q.push_back(e);
        @(posedge clk); #1;
        got = sample(); e = q.pop_front(); checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL fwd_sub got=%h exp=%h", got, e);
        end
        // Live source change with no clock edge.
        mem_aluR = 32'h30;
        #1;
        checks++;
        if (ex_aluR !== 32'h10) begin
            errors++;
            $display("FAIL fwd_live got=%h exp=%h", ex_aluR, 32'h10);
        end
        // Code 11 falls back to the latched register values.
        id_inA = 32'h9; id_inB = 32'h4; id_fwda = 2'b11; id_fwdb = 2'b11; id_aluc = 4'd3;
        id_rd = 5'd0; id_m2reg = 0;
        e = '{aluR: 32'hD, inB: 32'h4, pc: 32'd0, destR: 5'd0, zero: 1'b0, wreg: 1'b0,
              m2reg: 1'b0, wmem: 1'b0, branch: 1'b0, ins_type: 4'd0, ins_number: 4'd0};
        q.push_back(e);
        @(posedge clk); #1;
        got = sample(); e = q.pop_front(); checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL fwd_11 got=%h exp=%h", got, e);
        end
        clear_inputs();
    endtask

    task automatic test_imm_shift();
        obs_t got, e;
        id_aluimm = 1; id_imm = 32'hFFFF_FFFF; id_inA = 32'd1; id_inB = 32'h55;
        id_aluc = 4'd0; id_wmem = 1;
        e = '{aluR: 32'd0, inB: 32'h55, pc: 32'hFFFF_FFFC, destR: 5'd0, zero: 1'b1,
              wreg: 1'b0, m2reg: 1'b0, wmem: 1'b1, branch: 1'b0, ins_type: 4'd0,
              ins_number: 4'd0};
        q.push_back(e);
        @(posedge clk); #1;
        got = sample(); e = q.pop_front(); checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL imm_add got=%h exp=%h", got, e);
        end
        clear_inputs();
        id_shift = 1; id_imm = 32'h0000_0100; id_inA = 32'hFFFF; id_inB = 32'd1;
        id_aluc = 4'd7; id_rd = 5'd12;
        e = '{aluR: 32'h10, inB: 32'd1, pc: 32'h400, destR: 5'd12, zero: 1'b0,
              wreg: 1'b0, m2reg: 1'b0, wmem: 1'b0, branch: 1'b0, ins_type: 4'd0,
              ins_number: 4'd0};
        q.push_back(e);
        @(posedge clk); #1;
        got = sample(); e = q.pop_front(); checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL shift_sll got=%h exp=%h", got, e);
        end
        clear_inputs();
    endtask

    task automatic test_branch_slt();
        obs_t got, e;
        id_pc4 = 32'h100; id_imm = 32'hFFFF_FFFE; id_branch = 1; id_aluc = 4'd6;
        id_inA = 32'hFFFF_FFFF; id_inB = 32'd1; id_regrt = 1; id_rt = 5'd9; id_rd = 5'd4;
        e = '{aluR: 32'd1, inB: 32'd1, pc: 32'hF8, destR: 5'd9, zero: 1'b0, wreg: 1'b0,
              m2reg: 1'b0, wmem: 1'b0, branch: 1'b1, ins_type: 4'd0, ins_number: 4'd0};
        q.push_back(e);
        @(posedge clk); #1;
        got = sample(); e = q.pop_front(); checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL branch_slt got=%h exp=%h", got, e);
        end
        clear_inputs();
    endtask

    task automatic test_trace();
        obs_t got, e;
        ID_ins_type = 4'd3; ID_ins_number = 4'd5; id_inA = 32'd1; id_rd = 5'd1;
        e = '{aluR: 32'd1, inB: 32'd0, pc: 32'd0, destR: 5'd1, zero: 1'b0, wreg: 1'b0,
              m2reg: 1'b0, wmem: 1'b0, branch: 1'b0, ins_type: trace_exp(4'd3),
              ins_number: trace_exp(4'd5)};
        q.push_back(e);
        @(posedge clk); #1;
        got = sample(); e = q.pop_front(); checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL trace got=%h exp=%h", got, e);
        end
        clear_inputs();
    endtask

    // Back-to-back randomised instructions: one new instruction every cycle.
    task automatic test_back_to_back();
        obs_t got, e;
        logic [31:0] a, b, fa, fb;
        for (int i = 0; i < 40; i++) begin
            id_inA = $urandom; id_inB = $urandom; id_imm = $urandom; id_pc4 = $urandom;
            id_aluc = 4'($urandom_range(0, 15)); id_fwda = 2'($urandom);
            id_fwdb = 2'($urandom); id_aluimm = 1'($urandom); id_shift = 1'($urandom);
            id_regrt = 1'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
            id_wreg = 1'($urandom); id_m2reg = 1'($urandom); id_wmem = 1'($urandom);
            id_branch = 1'($urandom); ID_ins_type = 4'($urandom);
            ID_ins_number = 4'($urandom);
            mem_aluR = $urandom; wb_dest = $urandom;
            if (i % 8 == 0) begin
                id_inA = 32'h8000_0000; id_inB = 32'h7FFF_FFFF;
            end
            fa = (id_fwda == 2'b01) ? mem_aluR : (id_fwda == 2'b10) ? wb_dest : id_inA;
            fb = (id_fwdb == 2'b01) ? mem_aluR : (id_fwdb == 2'b10) ? wb_dest : id_inB;
            a  = id_shift  ? {27'b0, id_imm[10:6]} : fa;
            b  = id_aluimm ? id_imm : fb;
            e.aluR = ref_alu(id_aluc, a, b);
            e.inB = fb;
            e.pc = id_pc4 + id_imm * 32'd4;
            e.destR = id_regrt ? id_rt : id_rd;
            e.zero = (e.aluR == 32'd0);
            e.wreg = id_wreg; e.m2reg = id_m2reg; e.wmem = id_wmem; e.branch = id_branch;
            e.ins_type = trace_exp(ID_ins_type); e.ins_number = trace_exp(ID_ins_number);
            q.push_back(e);
            @(posedge clk); #1;
            got = sample(); e = q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL b2b[%0d] op=%0d got=%h exp=%h", i, id_aluc, got, e);
            end
        end
        clear_inputs();
    endtask

    task automatic test_mid_reset();
        obs_t got, e;
        id_inA = 32'd20; id_inB = 32'd22; id_wreg = 1; id_rd = 5'd6;
        e = '{aluR: 32'd42, inB: 32'd22, pc: 32'd0, destR: 5'd6, zero: 1'b0, wreg: 1'b1,
              m2reg: 1'b0, wmem: 1'b0, branch: 1'b0, ins_type: 4'd0, ins_number: 4'd0};
        q.push_back(e);
        @(posedge clk); #1;
        got = sample(); e = q.pop_front(); checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL pre_reset got=%h exp=%h", got, e);
        end
        // New instruction in flight while reset hits: it must be discarded.
        id_inA = 32'd3; id_inB = 32'd4; id_wmem = 1; id_rd = 5'd8;
        rst = 1'b1;
        q.push_back(reset_obs());
        @(posedge clk); #1;
        got = sample(); e = q.pop_front(); checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL mid_reset got=%h exp=%h", got, e);
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_add();
        test_forwarding();
        test_imm_shift();
        test_branch_slt();
        test_trace();
        test_back_to_back();
        test_mid_reset();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
